// File: rtl/led_pwm_pkg.sv
// Shared constants for the LED PWM driver: register map, field widths and reset values.
package led_pwm_pkg;

  localparam int DUTY_W  = 8;
  localparam int BLINK_W = 16;

  localparam logic [1:0] ADDR_DUTY   = 2'd0;
  localparam logic [1:0] ADDR_BLINK  = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam logic [DUTY_W-1:0]  DUTY_RST_VAL  = 8'hFF;
  localparam logic [BLINK_W-1:0] BLINK_RST_VAL = '0;

endpackage

// File: rtl/led_pwm_if.sv
// Avalon-MM slave bus bundle for the LED PWM driver register block.
interface led_pwm_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/led_blink_timer.sv
// Counts PWM frames and toggles the blink phase every BLINK frames.
// Only instantiated when LED_PWM_BLINK_EN is defined.
module led_blink_timer
  import led_pwm_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_start,
  input  logic [BLINK_W-1:0] blink,
  input  logic               blink_wr,
  output logic               phase
);

  logic [BLINK_W-1:0] frame_cnt;

  // A BLINK write restarts the on-phase and wins over a toggle on the same clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
      phase     <= 1'b1;
    end else if (blink_wr || (blink == '0)) begin
      frame_cnt <= '0;
      phase     <= 1'b1;
    end else if (frame_start) begin
      if (frame_cnt == (blink - BLINK_W'(1))) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + BLINK_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_pwm_driver.sv
// Frame-synchronous 8-bit PWM dimmer for the board LEDs with an Avalon register block.
// Optional blinking is enabled by defining LED_PWM_BLINK_EN.
module led_pwm_driver
  import led_pwm_pkg::*;
#(
  parameter int                PRESCALE = 196,
  parameter logic [DUTY_W-1:0] DUTY_RST = DUTY_RST_VAL
) (
  input  logic        clk,
  input  logic        reset_n,
  led_pwm_if.slave    bus,
  input  logic [7:0]  led_in,
  output logic [7:0]  led_out
);

  localparam int             PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0]        presc;
  logic [7:0]           pwm_cnt;
  logic                 tick;
  logic                 frame_start;
  logic [DUTY_W-1:0]    duty;
  logic [DUTY_W-1:0]    shadow_duty;
  logic [7:0]           shadow_pattern;
  logic                 pwm_on;
  logic                 phase;
  logic                 wr_en;
  logic [BLINK_W-1:0]   blink;

  assign wr_en       = bus.chipselect & ~bus.write_n;
  assign tick        = (presc == PRESC_MAX);
  assign frame_start = tick & (pwm_cnt == 8'hFF);
  assign pwm_on      = (shadow_duty == 8'hFF) || (pwm_cnt < shadow_duty);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty <= DUTY_RST;
    end else if (wr_en && (bus.address == ADDR_DUTY)) begin
      duty <= bus.writedata[DUTY_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else if (tick) begin
      presc   <= '0;
      pwm_cnt <= pwm_cnt + 8'd1;
    end else begin
      presc   <= presc + PW'(1);
    end
  end

  // Shadows latch only at frame_start, so a DUTY write on that same clock lands a frame later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_pattern <= '0;
      shadow_duty    <= DUTY_RST;
    end else if (frame_start) begin
      shadow_pattern <= led_in;
      shadow_duty    <= duty;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_out <= '0;
    end else begin
      led_out <= shadow_pattern & {8{pwm_on & phase}};
    end
  end

`ifdef LED_PWM_BLINK_EN
  logic blink_wr;
  logic unused_wdata;

  assign blink_wr     = wr_en && (bus.address == ADDR_BLINK);
  assign unused_wdata = ^bus.writedata[31:BLINK_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink <= BLINK_RST_VAL;
    end else if (blink_wr) begin
      blink <= bus.writedata[BLINK_W-1:0];
    end
  end

  led_blink_timer u_blink_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .blink       (blink),
    .blink_wr    (blink_wr),
    .phase       (phase)
  );
`else
  logic unused_wdata;

  assign unused_wdata = ^bus.writedata[31:DUTY_W];
  assign blink        = '0;
  assign phase        = 1'b1;
`endif

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DUTY:   bus.readdata = {{(32-DUTY_W){1'b0}}, duty};
      ADDR_BLINK:  bus.readdata = {{(32-BLINK_W){1'b0}}, blink};
      ADDR_STATUS: bus.readdata = {16'h0, shadow_pattern, 7'h0, phase};
      ADDR_RSVD:   bus.readdata = '0;
      default:     bus.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed, table-driven bench for led_pwm_driver with PRESCALE=2 (512-clock frames).
// Blink checks adapt to whether LED_PWM_BLINK_EN is defined.
module tb_led_pwm_driver;
  import led_pwm_pkg::*;

  localparam int PRESCALE = 2;
  localparam int FRAME    = 256 * PRESCALE;

  typedef struct {
    logic [7:0] duty;
    logic [7:0] pattern;
    int         on_len;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] led_in;
  logic [7:0] led_out;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  vec_t       vecs[5];

  led_pwm_if bus ();

  led_pwm_driver #(.PRESCALE(PRESCALE), .DUTY_RST(8'hFF)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .led_in  (led_in),
    .led_out (led_out)
  );

  always #5 clk = ~clk;

  // Edges since reset release; bench timebase for frame arithmetic.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int k);
    int guard = 0;
    while (cyc < k && guard < 100000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != k) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL wait_cyc: reached %0d, wanted %0d", cyc, k);
    end
  endtask

  task automatic check_led(input string name, input int k, input logic [7:0] exp);
    wait_cyc(k);
    check_output(name, {24'h0, led_out}, {24'h0, exp});
  endtask

  task automatic check_read(input string name, input logic [1:0] addr, input logic [31:0] exp);
    bus.address = addr;
    #1;
    check_output(name, bus.readdata, exp);
  endtask

  // Single-cycle Avalon write; called on a falling edge, returns on the next one.
  task automatic apply_stimulus(input logic [1:0] addr, input logic [31:0] data);
    bus.address    = addr;
    bus.writedata  = data;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  initial begin
    int base;
    int f;

    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    led_in         = 8'hA5;

    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_led", {24'h0, led_out}, 32'h0);
    check_read("reset_duty", ADDR_DUTY, 32'h0000_00FF);
    check_read("reset_blink", ADDR_BLINK, 32'h0);
    check_read("reset_status", ADDR_STATUS, 32'h0000_0001);
    @(negedge clk);
    reset_n = 1'b1;

    check_led("first_frame_pre", FRAME, 8'h00);
    check_led("first_frame_on", FRAME + 1, 8'hA5);
    check_read("first_status", ADDR_STATUS, 32'h0000_A501);
    check_led("first_frame_end", 2 * FRAME, 8'hA5);

    vecs[0] = '{duty: 8'h40, pattern: 8'hFF, on_len: 128};
    vecs[1] = '{duty: 8'h00, pattern: 8'hFF, on_len: 0};
    vecs[2] = '{duty: 8'hFF, pattern: 8'h5A, on_len: 512};
    vecs[3] = '{duty: 8'h80, pattern: 8'h3C, on_len: 256};
    vecs[4] = '{duty: 8'h01, pattern: 8'h81, on_len: 2};

    foreach (vecs[i]) begin
      base = FRAME * (cyc / FRAME + 1);
      apply_stimulus(ADDR_DUTY, {24'hDEAD00, vecs[i].duty});
      check_read($sformatf("vec%0d_duty_rd", i), ADDR_DUTY, {24'h0, vecs[i].duty});
      led_in = vecs[i].pattern;
      for (int j = 1; j <= FRAME; j++) begin
        wait_cyc(base + j);
        if (j <= 2 || j == vecs[i].on_len || j == vecs[i].on_len + 1 || j == 300 || j == FRAME)
          check_output($sformatf("vec%0d_led_j%0d", i, j), {24'h0, led_out},
                       {24'h0, (j <= vecs[i].on_len) ? vecs[i].pattern : 8'h00});
      end
    end

    // DUTY write on the frame_start clock: old duty (1) for one more frame.
    f = cyc + FRAME;
    wait_cyc(f - 1);
    apply_stimulus(ADDR_DUTY, 32'h0000_00FF);
    check_led("coinc_old_j1", f + 1, 8'h81);
    check_led("coinc_old_j2", f + 2, 8'h81);
    check_led("coinc_old_j3", f + 3, 8'h00);
    check_led("coinc_old_end", f + FRAME, 8'h00);
    check_led("coinc_new_j1", f + FRAME + 1, 8'h81);
    check_led("coinc_new_end", f + 2 * FRAME, 8'h81);

    // Pattern change mid-frame is deferred to the next frame.
    led_in = 8'h0F;
    base = cyc + FRAME;
    check_led("pat_first", base + 1, 8'h0F);
    wait_cyc(base + 200);
    led_in = 8'hF0;
    check_led("pat_mid_hold", base + 201, 8'h0F);
    check_led("pat_end_hold", base + FRAME, 8'h0F);
    check_led("pat_new", base + FRAME + 1, 8'hF0);
    check_read("pat_status", ADDR_STATUS, 32'h0000_F001);

    apply_stimulus(ADDR_RSVD, 32'hFFFF_FFFF);
    check_read("rsvd_read", ADDR_RSVD, 32'h0);
    apply_stimulus(ADDR_STATUS, 32'h0);
    check_read("status_ro", ADDR_STATUS, 32'h0000_F001);
    check_read("duty_kept", ADDR_DUTY, 32'h0000_00FF);

    base = FRAME * (cyc / FRAME + 1);
    wait_cyc(base);
    led_in = 8'hFF;
    wait_cyc(base + 10);
    apply_stimulus(ADDR_BLINK, {16'hBEEF, 16'd3});
`ifdef LED_PWM_BLINK_EN
    check_read("blink_rd", ADDR_BLINK, 32'h0000_0003);
    check_led("blink_on1", base + 600, 8'hFF);
    check_led("blink_on1_end", base + 3 * FRAME, 8'hFF);
    check_led("blink_off1", base + 3 * FRAME + 1, 8'h00);
    check_read("blink_off_status", ADDR_STATUS, 32'h0000_FF00);
    check_led("blink_off1_end", base + 6 * FRAME, 8'h00);
    check_led("blink_on2", base + 6 * FRAME + 1, 8'hFF);
    check_led("blink_on2_end", base + 9 * FRAME, 8'hFF);
    check_led("blink_off2", base + 9 * FRAME + 1, 8'h00);
    wait_cyc(base + 9 * FRAME + 100);
    apply_stimulus(ADDR_BLINK, 32'h0000_0003);
    check_output("rewrite_led_lag", {24'h0, led_out}, 32'h0);
    check_read("rewrite_status", ADDR_STATUS, 32'h0000_FF01);
    check_led("rewrite_led_on", base + 9 * FRAME + 102, 8'hFF);
    check_led("rewrite_hold", base + 12 * FRAME, 8'hFF);
    check_led("rewrite_off", base + 12 * FRAME + 1, 8'h00);
    apply_stimulus(ADDR_BLINK, 32'h0);
    @(negedge clk);
    check_output("blink0_led", {24'h0, led_out}, 32'h0000_00FF);
`else
    check_read("blink_rd_dis", ADDR_BLINK, 32'h0);
    check_led("noblink_f3", base + 3 * FRAME + 1, 8'hFF);
    check_read("noblink_status", ADDR_STATUS, 32'h0000_FF01);
    check_led("noblink_f6", base + 6 * FRAME, 8'hFF);
`endif

    // Reset asserted mid-frame while LEDs are lit.
    base = FRAME * (cyc / FRAME + 1);
    wait_cyc(base + 5);
    apply_stimulus(ADDR_DUTY, 32'h0000_0080);
    check_led("prerst_led", base + FRAME + 10, 8'hFF);
    reset_n = 1'b0;
    #1;
    check_output("rst_led_now", {24'h0, led_out}, 32'h0);
    check_read("rst_duty", ADDR_DUTY, 32'h0000_00FF);
    check_read("rst_blink", ADDR_BLINK, 32'h0);
    check_read("rst_status", ADDR_STATUS, 32'h0000_0001);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check_led("postrst_mid", 300, 8'h00);
    check_led("postrst_pre", FRAME, 8'h00);
    check_led("postrst_on", FRAME + 1, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
